// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// muldiv_unit_if : request/response bundle between ID/EX and the mul/div unit
// Rev 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = 3
);
  logic                start;
  logic                kill;
  logic [OP_WIDTH-1:0] op;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic                busy;
  logic                done;
  logic [WIDTH-1:0]    result;

  modport master (
    output start, kill, op, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, kill, op, a, b,
    output busy, done, result
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : iterative radix-2 RV32M multiply/divide with sign fix-up
// Rev 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [OP_WIDTH-1:0] c_OP_MUL    = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] c_OP_MULH   = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] c_OP_MULHSU = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] c_OP_MULHU  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] c_OP_DIV    = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] c_OP_DIVU   = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] c_OP_REM    = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] c_OP_REMU   = OP_WIDTH'(7);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam logic [WIDTH-1:0] c_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [OP_WIDTH-1:0] r_op;
  logic [2*WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]    r_opnd;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_early;
  logic [WIDTH-1:0]    r_early_val;
  logic                r_done;
  logic [WIDTH-1:0]    r_result;

  // ---------------- operand decode at acceptance ----------------
  logic             w_accept;
  logic             w_is_div;
  logic             w_sgn_a;
  logic             w_sgn_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_b_zero;
  logic             w_ovf;
  logic             w_early;
  logic [WIDTH-1:0] w_early_val;

  assign w_accept = ((r_state == c_IDLE) || (r_state == c_DONE)) && bus.start && !bus.kill;

  assign w_is_div = (bus.op == c_OP_DIV) || (bus.op == c_OP_DIVU) ||
                    (bus.op == c_OP_REM) || (bus.op == c_OP_REMU);

  assign w_sgn_a = ((bus.op == c_OP_MULH) || (bus.op == c_OP_MULHSU) ||
                    (bus.op == c_OP_DIV)  || (bus.op == c_OP_REM)) && bus.a[WIDTH-1];
  assign w_sgn_b = ((bus.op == c_OP_MULH) || (bus.op == c_OP_DIV) ||
                    (bus.op == c_OP_REM)) && bus.b[WIDTH-1];

  assign w_mag_a = w_sgn_a ? (-bus.a) : bus.a;
  assign w_mag_b = w_sgn_b ? (-bus.b) : bus.b;

  assign w_b_zero = (bus.b == '0);
  assign w_ovf    = ((bus.op == c_OP_DIV) || (bus.op == c_OP_REM)) &&
                    (bus.a == c_MIN) && (bus.b == '1);
  assign w_early  = w_is_div && (w_b_zero || w_ovf);

  // Divide-by-zero takes priority over the signed overflow corner
  always_comb begin
    w_early_val = '0;
    if (w_b_zero) begin
      if ((bus.op == c_OP_DIV) || (bus.op == c_OP_DIVU))
        w_early_val = '1;
      else
        w_early_val = bus.a;
    end else if (bus.op == c_OP_DIV) begin
      w_early_val = bus.a;
    end
  end

  // ---------------- iteration datapath ----------------
  logic               w_r_is_div;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_trial;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_r_is_div = (r_op == c_OP_DIV) || (r_op == c_OP_DIVU) ||
                      (r_op == c_OP_REM) || (r_op == c_OP_REMU);

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}, shifted left one bit per step
  assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
  assign w_div_next  = w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                          : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // ---------------- sign fix-up ----------------
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_val;

  assign w_prod = r_neg_q ? (-r_acc) : r_acc;
  assign w_quo  = r_neg_q ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? (-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_fix_val = w_rem;
    if (r_early) begin
      w_fix_val = r_early_val;
    end else begin
      case (r_op)
        c_OP_MUL:                          w_fix_val = w_prod[WIDTH-1:0];
        c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_fix_val = w_prod[2*WIDTH-1:WIDTH];
        c_OP_DIV, c_OP_DIVU:               w_fix_val = w_quo;
        default:                           w_fix_val = w_rem;
      endcase
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= c_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept)
          w_state_nxt = w_early ? c_FIX : c_CALC;
      end
      c_CALC: begin
        if (bus.kill)
          w_state_nxt = c_IDLE;
        else if (r_cnt == '0)
          w_state_nxt = c_FIX;
      end
      c_FIX: begin
        w_state_nxt = bus.kill ? c_IDLE : c_DONE;
      end
      c_DONE: begin
        if (w_accept)
          w_state_nxt = w_early ? c_FIX : c_CALC;
        else
          w_state_nxt = c_IDLE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.busy = (r_state == c_CALC) || (r_state == c_FIX);
  end

  assign bus.done   = r_done;
  assign bus.result = r_result;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_op        <= '0;
      r_acc       <= '0;
      r_opnd      <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_early     <= 1'b0;
      r_early_val <= '0;
      r_done      <= 1'b0;
      r_result    <= '0;
    end else begin
      r_done <= (r_state == c_FIX) && !bus.kill;

      if (w_accept) begin
        r_op        <= bus.op;
        r_neg_q     <= w_sgn_a ^ w_sgn_b;
        r_neg_r     <= w_sgn_a;
        r_early     <= w_early;
        r_early_val <= w_early_val;
        r_cnt       <= CW'(WIDTH-1);
        if (w_is_div) begin
          r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
          r_opnd <= w_mag_b;
        end else begin
          r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
          r_opnd <= w_mag_a;
        end
      end else if (r_state == c_CALC) begin
        r_cnt <= r_cnt - CW'(1);
        r_acc <= w_r_is_div ? w_div_next : w_mul_next;
      end

      // A kill landing on the FIX edge discards the result
      if ((r_state == c_FIX) && !bus.kill)
        r_result <= w_fix_val;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_muldiv_unit : directed scoreboard bench for the RV32M mul/div unit
// Rev 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W), .OP_WIDTH(3)) bus ();

  muldiv_unit #(.WIDTH(W), .OP_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string          tag;
    logic [W-1:0]   val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input string tag);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    sb.push_back('{tag, exp});
  endtask

  // Counts cycles after the current one until done, bounded; clears start on the first edge
  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = 0;
    do begin
      tick();
      bus.start = 1'b0;
      n++;
      if (bus.busy === 1'b1) nb++;
    end while ((bus.done !== 1'b1) && (n < 60));
  endtask

  task automatic finish_op(input int n, input int nb, input int exp_n, input int exp_nb,
                           input string tag);
    exp_t e;
    chk({tag, "_latency"}, n, exp_n);
    chk({tag, "_busy_cycles"}, nb, exp_nb);
    chk({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, bus.result, e.val);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input string tag,
                        input int exp_n, input int exp_nb);
    int n, nb;
    issue(op, a, b, exp, tag);
    wait_done(n, nb);
    finish_op(n, nb, exp_n, exp_nb, tag);
    tick();
    chk({tag, "_pulse_end"}, bus.done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb, seen;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    chk("rst_busy",   bus.busy,   1'b0);
    chk("rst_done",   bus.done,   1'b0);
    chk("rst_result", bus.result, '0);
    rst = 1'b0;
    tick();

    // Multiplies
    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul",    34, 33);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh",   34, 33);
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulhu",  34, 33);
    run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, "mulhsu", 34, 33);

    // Divides
    run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div",  34, 33);
    run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem",  34, 33);
    run_op(3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, "divu", 34, 33);
    run_op(3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, "remu", 34, 33);

    // Early-out corners
    run_op(3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "divu_by0", 2, 1);
    run_op(3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, "rem_by0",  2, 1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf",  2, 1);

    // Kill ten cycles into a divide
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'd100; bus.b = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    chk("kill_busy_before", bus.busy, 1'b1);
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    chk("kill_busy_after", bus.busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) seen++;
      tick();
    end
    chk("kill_no_done", seen, 0);
    chk("kill_result_held", bus.result, 32'h8000_0000);

    // start and kill together are ignored
    bus.start = 1'b1; bus.kill = 1'b1; bus.op = 3'd5; bus.a = 32'd9; bus.b = 32'd3;
    tick();
    bus.start = 1'b0; bus.kill = 1'b0;
    chk("startkill_busy", bus.busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done === 1'b1) seen++;
      tick();
    end
    chk("startkill_no_done", seen, 0);
    chk("startkill_result", bus.result, 32'h8000_0000);

    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf", 2, 1);

    // Back-to-back: second start in the DONE cycle
    issue(3'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, "b2b_mulhu");
    wait_done(n, nb);
    finish_op(n, nb, 34, 33, "b2b_mulhu");
    issue(3'd5, 32'd100, 32'd7, 32'd14, "b2b_divu");
    wait_done(n, nb);
    finish_op(n, nb, 34, 33, "b2b_divu");
    tick();
    chk("b2b_pulse_end", bus.done, 1'b0);

    // start while busy is ignored
    issue(3'd5, 32'd1000, 32'd10, 32'd100, "busy_start_divu");
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd3;
    wait_done(n, nb);
    finish_op(n, nb, 32, 31, "busy_start_divu");
    tick();

    // Asynchronous reset mid-calculation
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd5;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy",   bus.busy,   1'b0);
    chk("arst_done",   bus.done,   1'b0);
    chk("arst_result", bus.result, '0);
    tick();
    rst = 1'b0;
    tick();
    run_op(3'd0, 32'd3, 32'd5, 32'd15, "post_rst_mul", 34, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
